// File: rtl/lsu_mem_ctrl_if.sv
// Execute-stage request/response and data-memory signals of the load/store unit.
// The slave modport is the LSU's view; the master modport is the execute stage plus memory.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: byte-addressed requests onto a 64-bit word memory, with RMW for narrow stores.
// Optional macro LSU_BOUNDS_CHECK_EN faults word indices >= MEM_WORDS instead of wrapping.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.slave  bus
);
    localparam int unsigned XLEN   = 64;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned WIDX_W = XLEN - OFF_W;
    localparam int unsigned BYTES  = XLEN / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_RD, S_ST_WR, S_RMW_RD, S_RMW_WR, S_RESP
    } state_t;

    if (MEM_WORDS != (32'd1 << IDX_W)) begin : g_cfg_err
        $error("lsu_mem_ctrl: MEM_WORDS must equal 2**IDX_W");
    end

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [WIDX_W-1:0]   idx_q, idx_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                resp_valid_q, resp_valid_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;

    logic                req_err;
    logic [XLEN-1:0]     ld_ext;
    logic [XLEN-1:0]     st_merge;

    // Request legality: direction, funct3 encoding, natural alignment and optional range.
    always_comb begin
        logic [2:0] size_mask;
        logic       bad_f3;
        logic       misalign;
        logic       oob;
        case (bus.req_funct3[1:0])
            2'b00:   size_mask = 3'b000;
            2'b01:   size_mask = 3'b001;
            2'b10:   size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
        bad_f3   = bus.req_load ? (bus.req_funct3 == 3'b111) : bus.req_funct3[2];
        misalign = |(bus.req_addr[OFF_W-1:0] & size_mask);
        oob      = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
        oob      = (bus.req_addr[XLEN-1:OFF_W] >= WIDX_W'(MEM_WORDS));
`endif
        req_err  = (bus.req_load == bus.req_store) | bad_f3 | misalign | oob;
    end

    // Load lane select and sign/zero extension.
    always_comb begin
        logic [XLEN-1:0] s;
        s = bus.mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{56{s[7]}},  s[7:0]};
            3'b001:  ld_ext = {{48{s[15]}}, s[15:0]};
            3'b010:  ld_ext = {{32{s[31]}}, s[31:0]};
            3'b100:  ld_ext = {56'd0, s[7:0]};
            3'b101:  ld_ext = {48'd0, s[15:0]};
            3'b110:  ld_ext = {32'd0, s[31:0]};
            default: ld_ext = s;
        endcase
    end

    // Narrow store merge into the word just read.
    always_comb begin
        logic [BYTES-1:0] be_base;
        logic [BYTES-1:0] be;
        logic [XLEN-1:0]  bit_mask;
        logic [XLEN-1:0]  wshift;
        case (f3_q[1:0])
            2'b00:   be_base = 8'h01;
            2'b01:   be_base = 8'h03;
            default: be_base = 8'h0F;
        endcase
        be = be_base << off_q;
        for (int i = 0; i < int'(BYTES); i++) begin
            bit_mask[i*8 +: 8] = {8{be[i]}};
        end
        wshift   = wdata_q << {off_q, 3'b000};
        st_merge = (bus.mem_rdata & ~bit_mask) | (wshift & bit_mask);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        off_d       = off_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    f3_d    = bus.req_funct3;
                    off_d   = bus.req_addr[OFF_W-1:0];
                    idx_d   = bus.req_addr[XLEN-1:OFF_W];
                    wdata_d = bus.req_wdata;
                    if (req_err) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (bus.req_load) begin
                        state_d    = S_LD_RD;
                        mem_read_d = 1'b1;
                    end else if (bus.req_funct3[1:0] == 2'b11) begin
                        state_d     = S_ST_WR;
                        mem_write_d = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        state_d    = S_RMW_RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            S_LD_RD: begin
                state_d = S_RESP;
                rdata_d = ld_ext;
                err_d   = 1'b0;
            end
            S_ST_WR: begin
                state_d = S_RESP;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            S_RMW_RD: begin
                state_d     = S_RMW_WR;
                mem_wdata_d = st_merge;
                mem_write_d = 1'b1;
            end
            S_RMW_WR: begin
                state_d = S_RESP;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            S_RESP: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // Strobes are masked by reset so an aborted access never reaches memory.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_read   = mem_read_q & rst_n;
    assign bus.mem_write  = mem_write_q & rst_n;
    assign bus.mem_addr   = {3'b000, idx_q};
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 1024-word behavioural data memory.
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [63:0] mem [0:1023];

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.MEM_WORDS(1024), .IDX_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request and compare latency, write timing/data and response.
    task automatic run_req(input string tag, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wdata, input int exp_lat,
                           input int exp_wr_cyc, input logic [63:0] exp_wdata,
                           input logic exp_err, input logic [63:0] exp_rdata);
        int          lat;
        int          wr_cyc;
        logic [63:0] wd;
        logic [63:0] wa;
        logic        err;
        logic [63:0] rd;
        lat = 0; wr_cyc = 0; wd = '0; wa = '0; err = 1'b0; rd = '0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        check({tag, ".ready"}, 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_write) begin
                wr_cyc = k;
                wd     = bus.mem_wdata;
                wa     = bus.mem_addr;
            end
            if (bus.resp_valid) begin
                lat = k;
                err = bus.resp_err;
                rd  = bus.resp_rdata;
                break;
            end
        end
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".wr_cyc"}, 64'(wr_cyc), 64'(exp_wr_cyc));
        if (exp_wr_cyc != 0) begin
            check({tag, ".wdata"}, wd, exp_wdata);
            check({tag, ".waddr"}, wa, addr >> 3);
        end
        check({tag, ".err"}, 64'(err), 64'(exp_err));
        check({tag, ".rdata"}, rd, exp_rdata);
    endtask

    initial begin
        logic seen_resp;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst.resp_err",   64'(bus.resp_err),   64'd0);
        check("rst.resp_rdata", bus.resp_rdata,      64'd0);
        check("rst.mem_wdata",  bus.mem_wdata,       64'd0);
        check("rst.mem_addr",   bus.mem_addr,        64'd0);
        check("rst.ready",      64'(bus.req_ready),  64'd1);

        // SD then LD of the same word
        run_req("sd40", 0, 1, 3'b011, 64'h40, 64'h1122334455667788, 2, 1, 64'h1122334455667788, 0, 64'd0);
        run_req("ld40", 1, 0, 3'b011, 64'h40, 64'd0, 2, 0, 64'd0, 0, 64'h1122334455667788);
        // SB read-modify-write
        run_req("sb43", 0, 1, 3'b000, 64'h43, 64'hAB, 3, 2, 64'h11223344AB667788, 0, 64'd0);
        run_req("ld40b", 1, 0, 3'b011, 64'h40, 64'd0, 2, 0, 64'd0, 0, 64'h11223344AB667788);
        // Extension cases on 0xF080
        run_req("sd40c", 0, 1, 3'b011, 64'h40, 64'h000000000000F080, 2, 1, 64'h000000000000F080, 0, 64'd0);
        run_req("lb40",  1, 0, 3'b000, 64'h40, 64'd0, 2, 0, 64'd0, 0, 64'hFFFFFFFFFFFFFF80);
        run_req("lbu40", 1, 0, 3'b100, 64'h40, 64'd0, 2, 0, 64'd0, 0, 64'h0000000000000080);
        run_req("lh40",  1, 0, 3'b001, 64'h40, 64'd0, 2, 0, 64'd0, 0, 64'hFFFFFFFFFFFFF080);
        run_req("lhu40", 1, 0, 3'b101, 64'h40, 64'd0, 2, 0, 64'd0, 0, 64'h000000000000F080);
        run_req("lw40",  1, 0, 3'b010, 64'h40, 64'd0, 2, 0, 64'd0, 0, 64'h000000000000F080);
        // Upper-half SW / SH merges and loads
        run_req("sw44",  0, 1, 3'b010, 64'h44, 64'hFFFFFFFF87654321, 3, 2, 64'h876543210000F080, 0, 64'd0);
        run_req("lwu44", 1, 0, 3'b110, 64'h44, 64'd0, 2, 0, 64'd0, 0, 64'h0000000087654321);
        run_req("lw44",  1, 0, 3'b010, 64'h44, 64'd0, 2, 0, 64'd0, 0, 64'hFFFFFFFF87654321);
        run_req("sh46",  0, 1, 3'b001, 64'h46, 64'h000000000000BEEF, 3, 2, 64'hBEEF43210000F080, 0, 64'd0);
        run_req("lh46",  1, 0, 3'b001, 64'h46, 64'd0, 2, 0, 64'd0, 0, 64'hFFFFFFFFFFFFBEEF);
        run_req("lhu46", 1, 0, 3'b101, 64'h46, 64'd0, 2, 0, 64'd0, 0, 64'h000000000000BEEF);
        // Faulting requests: 1-cycle response, no write, rdata cleared
        run_req("lw42_mis",  1, 0, 3'b010, 64'h42, 64'd0, 1, 0, 64'd0, 1, 64'd0);
        run_req("sh41_mis",  0, 1, 3'b001, 64'h41, 64'h1234, 1, 0, 64'd0, 1, 64'd0);
        run_req("ld_f3_111", 1, 0, 3'b111, 64'h40, 64'd0, 1, 0, 64'd0, 1, 64'd0);
        run_req("ld_and_st", 1, 1, 3'b011, 64'h40, 64'd0, 1, 0, 64'd0, 1, 64'd0);
        run_req("no_dir",    0, 0, 3'b011, 64'h40, 64'd0, 1, 0, 64'd0, 1, 64'd0);
        run_req("st_f3_100", 0, 1, 3'b100, 64'h40, 64'd0, 1, 0, 64'd0, 1, 64'd0);
        check("mem8_after_err", mem[8], 64'hBEEF43210000F080);

        // Reset during RMW_WR aborts the SW to word 9
        run_req("sd48", 0, 1, 3'b011, 64'h48, 64'hDEADBEEFCAFEF00D, 2, 1, 64'hDEADBEEFCAFEF00D, 0, 64'd0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 64'h48;
        bus.req_wdata  = 64'h12345678;
        check("sw48.ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_wr.mem_write", 64'(bus.mem_write), 64'd0);
        seen_resp = bus.resp_valid;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.resp_valid) seen_resp = 1'b1;
        end
        check("rst_wr.no_resp", 64'(seen_resp), 64'd0);
        check("rst_wr.ready", 64'(bus.req_ready), 64'd1);
        check("rst_wr.mem_addr", bus.mem_addr, 64'd0);
        check("rst_wr.mem9", mem[9], 64'hDEADBEEFCAFEF00D);
        run_req("ld48", 1, 0, 3'b011, 64'h48, 64'd0, 2, 0, 64'd0, 0, 64'hDEADBEEFCAFEF00D);

        // Index 1024: fault when range-checked, wrap to word 0 otherwise
        run_req("sd0", 0, 1, 3'b011, 64'h0, 64'h0123456789ABCDEF, 2, 1, 64'h0123456789ABCDEF, 0, 64'd0);
`ifdef LSU_BOUNDS_CHECK_EN
        run_req("ld2000", 1, 0, 3'b011, 64'h2000, 64'd0, 1, 0, 64'd0, 1, 64'd0);
`else
        run_req("ld2000", 1, 0, 3'b011, 64'h2000, 64'd0, 2, 0, 64'd0, 0, 64'h0123456789ABCDEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
